// File: rtl/mux_pkg.sv
// Shared constants for the select-mux datapath and its output buffering stage.
package mux_pkg;

  // Width of the data field produced by the 7-bit select mux.
  localparam int MUX_WIDTH      = 7;
  // Default number of entries in the downstream word FIFO.
  localparam int MUX_FIFO_DEPTH = 4;

endpackage : mux_pkg

// File: rtl/mux_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module mux_fifo_mem
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int DEPTH = MUX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are meaningless until written, so the array carries no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : mux_fifo_mem

// File: rtl/mux_word_fifo.sv
// First-word-fall-through buffer behind the select mux, with optional
// repeat suppression, occupancy output and a sticky overflow flag.
//
// Handshakes: a word moves across an interface only on a cycle where its
// valid and ready are both high at the rising edge. in_ready depends on the
// stored level alone (never on out_ready), so a full FIFO refuses a word even
// when a pop happens in the same cycle. out_valid/out_word never depend on
// in_valid. Once out_valid is high the head word holds until it is popped.
module mux_word_fifo
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int DEPTH = MUX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dedup_en,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             has_last_q, has_last_d;
  logic             ovf_q, ovf_d;

  logic             suppress;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_word;

  // A repeat is judged only against the last word actually stored.
  assign suppress  = dedup_en & has_last_q & (in_word == last_q);
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready & ~suppress;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;
  assign overflow  = ovf_q;
  // Storage is undefined when empty; present zero so the idle bus is clean.
  assign out_word  = out_valid ? head_word : '0;

  mux_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (tail_q),
    .wdata_i (in_word),
    .raddr_i (head_q),
    .rdata_o (head_word)
  );

  // Next-state for pointers, occupancy, dedup history and overflow.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    last_d     = last_q;
    has_last_d = has_last_q;
    ovf_d      = ovf_q;

    // Pointers are log2(DEPTH) bits wide, so they wrap at DEPTH naturally.
    if (push) begin
      tail_d     = tail_q + 1'b1;
      last_d     = in_word;
      has_last_d = 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // A new full-drop outranks a clear in the same cycle.
    if (in_valid && !in_ready && !suppress) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State register; reset empties the FIFO and forgets the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      last_q     <= '0;
      has_last_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      last_q     <= last_d;
      has_last_q <= has_last_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule : mux_word_fifo

// File: tb/tb_mux_word_fifo.sv
// Self-checking bench for mux_word_fifo: directed vector table, async-reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_mux_word_fifo;

  localparam int W     = 7;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_word = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          dedup_en = 1'b0;
  logic [W-1:0]  out_word;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  always #5 clk = ~clk;

  mux_word_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dedup_en  (dedup_en),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit iv, input int w, input bit dd, input bit ordy, input bit clr);
    in_valid  = iv;
    in_word   = W'(w);
    dedup_en  = dd;
    out_ready = ordy;
    clr_ovf   = clr;
  endtask

  // Advance one edge; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit iv; int w; bit dd; bit ordy; bit clr;
    int e_lvl; bit e_ov; int e_ow; bit e_ir; bit e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit iv, input int w, input bit dd, input bit ordy, input bit clr,
                     input int e_lvl, input bit e_ov, input int e_ow, input bit e_ir, input bit e_ovf);
    vec_t v;
    v = '{iv, w, dd, ordy, clr, e_lvl, e_ov, e_ow, e_ir, e_ovf};
    tbl.push_back(v);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           m_has_last;
  logic [W-1:0] m_last;
  bit           m_ovf;

  task automatic model_reset();
    exp_q.delete();
    m_has_last = 0;
    m_last     = '0;
    m_ovf      = 0;
  endtask

  // One clock edge of the buffer, from the behavioural rules.
  task automatic model_edge(input bit iv, input logic [W-1:0] w, input bit dd,
                            input bit ordy, input bit clr);
    bit full, supp, do_push, do_pop;
    full    = (exp_q.size() == DEPTH);
    supp    = dd && m_has_last && (w == m_last);
    do_push = iv && !full && !supp;
    do_pop  = (exp_q.size() > 0) && ordy;
    if (iv && full && !supp) m_ovf = 1;
    else if (clr)            m_ovf = 0;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(w);
      m_last     = w;
      m_has_last = 1;
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, " level"},     int'(level),     exp_q.size());
    chk({tag, " out_valid"}, int'(out_valid), int'(exp_q.size() > 0));
    chk({tag, " in_ready"},  int'(in_ready),  int'(exp_q.size() != DEPTH));
    chk({tag, " overflow"},  int'(overflow),  int'(m_ovf));
    if (exp_q.size() > 0) chk({tag, " out_word"}, int'(out_word), int'(exp_q[0]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Expected state after each edge, derived by hand from the rules.
    //   iv  w     dd ordy clr   lvl ov ow    ir ovf
    add(1, 'h15, 0, 0, 0,   1, 1, 'h15, 1, 0);  // first word falls through
    add(0, 'h00, 0, 1, 0,   0, 0, 'h00, 1, 0);  // pulse out_ready: empty
    add(1, 'h01, 0, 0, 0,   1, 1, 'h01, 1, 0);
    add(1, 'h02, 0, 0, 0,   2, 1, 'h01, 1, 0);
    add(1, 'h03, 0, 0, 0,   3, 1, 'h01, 1, 0);
    add(1, 'h04, 0, 0, 0,   4, 1, 'h01, 0, 0);  // full
    add(1, 'h05, 0, 0, 0,   4, 1, 'h01, 0, 1);  // dropped -> overflow
    add(0, 'h00, 0, 1, 1,   3, 1, 'h02, 1, 0);  // pop + plain clear
    add(0, 'h00, 0, 1, 0,   2, 1, 'h03, 1, 0);
    add(1, 'h33, 0, 1, 0,   2, 1, 'h04, 1, 0);  // push+pop at level 2
    add(0, 'h00, 0, 1, 0,   1, 1, 'h33, 1, 0);
    add(0, 'h00, 0, 1, 0,   0, 0, 'h00, 1, 0);
    add(1, 'h2A, 1, 0, 0,   1, 1, 'h2A, 1, 0);  // dedup on
    add(1, 'h2A, 1, 0, 0,   1, 1, 'h2A, 1, 0);  // repeat dropped
    add(1, 'h2B, 1, 0, 0,   2, 1, 'h2A, 1, 0);
    add(1, 'h2A, 1, 0, 0,   3, 1, 'h2A, 1, 0);
    add(0, 'h00, 0, 1, 0,   2, 1, 'h2B, 1, 0);
    add(0, 'h00, 0, 1, 0,   1, 1, 'h2A, 1, 0);
    add(0, 'h00, 0, 1, 0,   0, 0, 'h00, 1, 0);
    add(1, 'h2A, 0, 0, 0,   1, 1, 'h2A, 1, 0);  // dedup off: all kept
    add(1, 'h2A, 0, 0, 0,   2, 1, 'h2A, 1, 0);
    add(1, 'h2B, 0, 0, 0,   3, 1, 'h2A, 1, 0);
    add(1, 'h2A, 0, 0, 0,   4, 1, 'h2A, 0, 0);
    add(1, 'h11, 0, 1, 0,   3, 1, 'h2A, 1, 1);  // full: pop ok, push refused
    add(1, 'h12, 0, 0, 0,   4, 1, 'h2A, 0, 1);
    add(1, 'h13, 0, 0, 1,   4, 1, 'h2A, 0, 1);  // set beats clear
    add(0, 'h00, 0, 0, 1,   4, 1, 'h2A, 0, 0);  // clear alone
    add(1, 'h12, 1, 0, 0,   4, 1, 'h2A, 0, 0);  // suppressed while full: no overflow
    add(0, 'h00, 0, 1, 0,   3, 1, 'h2B, 1, 0);
    add(1, 'h2A, 0, 1, 0,   3, 1, 'h2A, 1, 0);  // leaves last accepted = 0x2A

    // Reset state, checked while rst_n is still low.
    #2;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_word",  int'(out_word),  0);
    chk("rst in_ready",  int'(in_ready),  1);
    chk("rst level",     int'(level),     0);
    chk("rst overflow",  int'(overflow),  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].w, tbl[i].dd, tbl[i].ordy, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d level", i),     int'(level),     tbl[i].e_lvl);
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("vec%0d in_ready", i),  int'(in_ready),  int'(tbl[i].e_ir));
      chk($sformatf("vec%0d overflow", i),  int'(overflow),  int'(tbl[i].e_ovf));
      if (tbl[i].e_ov) chk($sformatf("vec%0d out_word", i), int'(out_word), tbl[i].e_ow);
    end

    // Async reset between edges at level 3: outputs clear with no edge.
    drive(0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async level",     int'(level),     0);
    chk("async in_ready",  int'(in_ready),  1);
    chk("async overflow",  int'(overflow),  0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // History was forgotten: a word equal to the old last word is accepted.
    drive(1, 'h2A, 1, 0, 0);
    tick();
    chk("post-rst level",    int'(level),    1);
    chk("post-rst out_word", int'(out_word), 'h2A);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("post-rst drain", int'(level), 0);

    // Randomized traffic against the reference model (starts empty, no history).
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      bit           r_iv, r_dd, r_or, r_clr;
      logic [W-1:0] r_w;
      r_iv  = ($urandom_range(0, 3) != 0);
      r_w   = W'($urandom_range(0, 3) + ((c / 150) << 4));
      r_dd  = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r_or  = ($urandom_range(0, 99) < (c % 300 < 150 ? 35 : 75));
      r_clr = ($urandom_range(0, 9) == 0);
      drive(r_iv, int'(r_w), r_dd, r_or, r_clr);
      model_edge(r_iv, r_w, r_dd, r_or, r_clr);
      tick();
      model_compare($sformatf("rnd%0d", c));
    end
    drive(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mux_word_fifo
